// File: rtl/dvi_timing_gen.sv
// Video timing generator: raster counters, registered pixel-request decode and a
// PIPE_LAT-deep delay line that aligns DE/HSYNC/VSYNC with returned colour data.
module dvi_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned X_POS_W  = 10,
  parameter int unsigned Y_POS_W  = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic               req_o,
  output logic [X_POS_W-1:0] x_pos_o,
  output logic [Y_POS_W-1:0] y_pos_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_POS_W-1:0] H_LAST   = X_POS_W'(H_TOTAL - 1);
  localparam logic [X_POS_W-1:0] H_ACT    = X_POS_W'(H_ACTIVE);
  localparam logic [X_POS_W-1:0] HS_BEGIN = X_POS_W'(H_ACTIVE + H_FP);
  localparam logic [X_POS_W-1:0] HS_END   = X_POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [Y_POS_W-1:0] V_LAST   = Y_POS_W'(V_TOTAL - 1);
  localparam logic [Y_POS_W-1:0] V_ACT    = Y_POS_W'(V_ACTIVE);
  localparam logic [Y_POS_W-1:0] VS_BEGIN = Y_POS_W'(V_ACTIVE + V_FP);
  localparam logic [Y_POS_W-1:0] VS_END   = Y_POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Raster counters
  logic [X_POS_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_POS_W-1:0] v_cnt_q, v_cnt_d;

  // Stage 0 decode
  logic               req_q, req_d;
  logic [X_POS_W-1:0] x_pos_q, x_pos_d;
  logic [Y_POS_W-1:0] y_pos_q, y_pos_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               hs_act_q, hs_act_d;
  logic               vs_act_q, vs_act_d;

  // Delay line entries hold {req, hs_act, vs_act}; all-zero is the idle state.
  logic [2:0] pipe_q [PIPE_LAT];

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    req_d         = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    x_pos_d       = req_d ? h_cnt_q : '0;
    y_pos_d       = req_d ? v_cnt_q : '0;
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    hs_act_d      = (h_cnt_q >= HS_BEGIN) && (h_cnt_q <= HS_END);
    vs_act_d      = (v_cnt_q >= VS_BEGIN) && (v_cnt_q <= VS_END);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      req_q         <= 1'b0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_act_q      <= 1'b0;
      vs_act_q      <= 1'b0;
    end else if (en_i) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      req_q         <= req_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_act_q      <= hs_act_d;
      vs_act_q      <= vs_act_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (en_i) begin
      pipe_q[0] <= {req_q, hs_act_q, vs_act_q};
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign req_o         = req_q;
  assign x_pos_o       = x_pos_q;
  assign y_pos_o       = y_pos_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign de_o          = pipe_q[PIPE_LAT-1][2];
  assign hsync_o       = ~(pipe_q[PIPE_LAT-1][1] ^ HS_POL);
  assign vsync_o       = ~(pipe_q[PIPE_LAT-1][0] ^ VS_POL);

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen in the small 8x6 mode: one instance with latency 2 and
// active-low syncs, one with latency 1 and active-high syncs, both fed the same stimulus.
module tb_dvi_timing_gen;

  typedef struct packed {
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       de;
    logic       hs;
    logic       vs;
  } out_t;

  typedef struct {
    bit   rst;
    bit   en;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic       req_a, ls_a, fs_a, de_a, hs_a, vs_a;
  logic [9:0] x_a, y_a;
  logic       req_b, ls_b, fs_b, de_b, hs_b, vs_b;
  logic [9:0] x_b, y_b;
  out_t       act_a, act_b;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;  // enabled cycles since the last reset

  always #5 clk = ~clk;

  dvi_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(2), .X_POS_W(10), .Y_POS_W(10)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .req_o(req_a), .x_pos_o(x_a), .y_pos_o(y_a),
    .line_start_o(ls_a), .frame_start_o(fs_a),
    .de_o(de_a), .hsync_o(hs_a), .vsync_o(vs_a)
  );

  dvi_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(1), .X_POS_W(10), .Y_POS_W(10)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .req_o(req_b), .x_pos_o(x_b), .y_pos_o(y_b),
    .line_start_o(ls_b), .frame_start_o(fs_b),
    .de_o(de_b), .hsync_o(hs_b), .vsync_o(vs_b)
  );

  assign act_a = {req_a, x_a, y_a, ls_a, fs_a, de_a, hs_a, vs_a};
  assign act_b = {req_b, x_b, y_b, ls_b, fs_b, de_b, hs_b, vs_b};

  // Raster position of the pixel shown at stage 0 after k enabled cycles (k >= 1).
  function automatic int pix_h(int kk);
    return (kk - 1) % 8;
  endfunction

  function automatic int pix_v(int kk);
    return ((kk - 1) / 8) % 6;
  endfunction

  // Outputs expected after kk enabled cycles since reset.
  function automatic out_t model(int kk, int lat, bit pol);
    out_t o;
    int   h, v, j;
    bit   hs_act, vs_act;
    o    = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    if (kk >= 1) begin
      h     = pix_h(kk);
      v     = pix_v(kk);
      o.req = (h < 4) && (v < 3);
      if (o.req) begin
        o.x = 10'(h);
        o.y = 10'(v);
      end
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
    end
    j = kk - lat;
    if (j >= 1) begin
      h      = pix_h(j);
      v      = pix_v(j);
      hs_act = (h >= 5) && (h <= 6);
      vs_act = (v == 4);
      o.de   = (h < 4) && (v < 3);
      o.hs   = pol ? hs_act : !hs_act;
      o.vs   = pol ? vs_act : !vs_act;
    end
    return o;
  endfunction

  function automatic vec_t mk(bit r, bit e, bit req, int x, int y, bit ls, bit fs,
                              bit de, bit hs, bit vs);
    vec_t t;
    t.rst = r;
    t.en  = e;
    t.exp = {req, 10'(x), 10'(y), ls, fs, de, hs, vs};
    return t;
  endfunction

  task automatic check_out(string name, out_t act, out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got req=%b x=%0d y=%0d ls=%b fs=%b de=%b hs=%b vs=%b, want req=%b x=%0d y=%0d ls=%b fs=%b de=%b hs=%b vs=%b",
               name, k, act.req, act.x, act.y, act.ls, act.fs, act.de, act.hs, act.vs,
               exp.req, exp.x, exp.y, exp.ls, exp.fs, exp.de, exp.hs, exp.vs);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one edge, then compare both instances against the model.
  task automatic step(bit r, bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) k = 0;
    else if (e) k++;
    #1;
    check_out("model_a", act_a, model(k, 2, 1'b0));
    check_out("model_b", act_b, model(k, 1, 1'b1));
  endtask

  vec_t tbl[13];

  initial begin
    int guard;
    int c_req, c_fs, c_hs, c_vs, c_deb, c_hsb, c_ybig;

    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[1]  = mk(0, 1, 1, 0, 0, 1, 1, 0, 1, 1);
    tbl[2]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 1);
    tbl[3]  = mk(0, 1, 1, 2, 0, 0, 0, 1, 1, 1);
    tbl[4]  = mk(0, 1, 1, 3, 0, 0, 0, 1, 1, 1);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
    tbl[10] = mk(0, 1, 1, 1, 1, 0, 0, 0, 1, 1);
    tbl[11] = mk(0, 1, 1, 2, 1, 0, 0, 1, 1, 1);
    tbl[12] = mk(0, 0, 1, 2, 1, 0, 0, 1, 1, 1);

    step(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].en);
      check_out($sformatf("vec%0d", i), act_a, tbl[i].exp);
    end

    // Two whole frames in steady state: every periodic count is fixed.
    c_req = 0; c_fs = 0; c_hs = 0; c_vs = 0; c_deb = 0; c_hsb = 0; c_ybig = 0;
    for (int i = 0; i < 96; i++) begin
      step(1'b0, 1'b1);
      c_req  += int'(req_a);
      c_fs   += int'(fs_a);
      c_hs   += int'(!hs_a);
      c_vs   += int'(!vs_a);
      c_deb  += int'(de_b);
      c_hsb  += int'(hs_b);
      c_ybig += int'(y_a > 10'd2);
    end
    check_int("req_per_2frames", c_req, 24);
    check_int("frame_starts", c_fs, 2);
    check_int("hsync_low_cycles", c_hs, 24);
    check_int("vsync_low_cycles", c_vs, 16);
    check_int("de_b_cycles", c_deb, 24);
    check_int("hsync_b_high_cycles", c_hsb, 24);
    check_int("y_over_2", c_ybig, 0);

    // Pause for 5 cycles while pixel x=2 is on the request port.
    guard = 0;
    while (!(pix_h(k + 1) == 2 && pix_v(k + 1) < 3) && guard < 100) begin
      step(1'b0, 1'b1);
      guard++;
    end
    step(1'b0, 1'b1);
    check_int("pause_setup_x", int'(x_a), 2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check_int("paused_x", int'(x_a), 2);
    end
    step(1'b0, 1'b1);
    check_int("resume_x", int'(x_a), 3);

    // Reset pulse while (3,1) is presented.
    guard = 0;
    while (!(pix_h(k + 1) == 3 && pix_v(k + 1) == 1) && guard < 100) begin
      step(1'b0, 1'b1);
      guard++;
    end
    step(1'b0, 1'b1);
    check_int("rst_setup_xy", int'({x_a, y_a}), int'({10'd3, 10'd1}));
    step(1'b1, 1'b1);
    check_out("rst_mid_a", act_a, {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    check_out("rst_mid_b", act_b, {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step(1'b0, 1'b1);
    check_out("restart_a", act_a, {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});

    // Random enable/reset traffic against the model.
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
